// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives L1i, buffers fetched words for decode and
// handles execute redirects, including ones that land while an L1i miss is in flight.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] l1i_address,
  input  logic [31:0] l1i_output_data,
  input  logic        l1i_hit,
  input  logic        l1i_ready,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [31:0]          pc, pc_nxt, target, target_nxt;
  logic [DEPTH-1:0][31:0] buf_data, buf_pc;
  logic [AW-1:0]        head, tail;
  logic [CW-1:0]        count;
  logic                 hit_rdy, fill, pop, flush;
  logic [31:0]          redir_al;

  assign hit_rdy     = l1i_hit && l1i_ready;
  assign redir_al    = redirect_pc & ~32'd3;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_data  = buf_data[head];
  assign instr_pc    = buf_pc[head];
  // pc is never touched between the miss and its return, so it is the held miss address
  assign l1i_address = pc;
  assign fetch_busy  = reset || (state == DRAIN) || !hit_rdy;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    target_nxt = target;
    fill       = 1'b0;
    flush      = 1'b0;
    case (state)
      FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (l1i_hit) begin
            pc_nxt = redir_al;
          end else begin
            target_nxt = redir_al;
            state_nxt  = DRAIN;
          end
        end else if (hit_rdy && (count < CW'(DEPTH))) begin
          fill   = 1'b1;
          pc_nxt = pc + 32'd4;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          target_nxt = redir_al;
        end
        // the returning word belongs to the abandoned path and is dropped
        if (hit_rdy) begin
          pc_nxt    = redirect_valid ? redir_al : target;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      target   <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      buf_data <= '0;
      buf_pc   <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      target <= target_nxt;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (fill) begin
          buf_data[tail] <= l1i_output_data;
          buf_pc[tail]   <= pc;
          tail           <= tail + AW'(1);
        end
        if (pop) head <= head + AW'(1);
        count <= count + CW'(fill) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected PCs to a scoreboard,
// a negedge monitor pops and compares every accepted instruction.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] l1i_address, l1i_output_data;
  logic        l1i_hit, l1i_ready, hit_en = 1'b0;
  logic        instr_valid, instr_ready = 1'b1;
  logic [31:0] instr_data, instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  // L1i stand-in: the word at address A is ~A
  assign l1i_hit         = hit_en;
  assign l1i_ready       = hit_en;
  assign l1i_output_data = ~l1i_address;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .l1i_address(l1i_address), .l1i_output_data(l1i_output_data),
    .l1i_hit(l1i_hit), .l1i_ready(l1i_ready),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_busy(fetch_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got pc %h data %h expected none", instr_pc, instr_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_chk++;
        if (instr_pc === e && instr_data === ~e) n_pass++;
        else $display("FAIL sb_instr: got pc %h data %h expected pc %h data %h",
                      instr_pc, instr_data, e, ~e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    step(2);
    @(negedge clock);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_addr", l1i_address, 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'd1);

    // streaming hits: one instruction per cycle from cycle 1
    @(posedge clock); #1;
    reset = 1'b0; hit_en = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      if (k == 4) hit_en = 1'b0;
      @(negedge clock);
      chk("stream_valid", 32'(instr_valid), 32'd1);
      chk("stream_pc", instr_pc, 32'((k - 1) * 4));
    end
    step(2);
    chk("stream_addr", l1i_address, 32'h10);
    chk("stream_busy", 32'(fetch_busy), 32'd1);
    chk("stream_empty", 32'(instr_valid), 32'd0);

    // backpressure with a full buffer
    reset = 1'b1; instr_ready = 1'b0;
    step(1);
    reset = 1'b0; hit_en = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    step(5);
    @(negedge clock);
    chk("full_addr", l1i_address, 32'h8);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_head", instr_pc, 32'h0);
    @(posedge clock); #1;
    instr_ready = 1'b1;
    step(2);
    hit_en = 1'b0;
    step(3);

    // plain miss at 0x40
    hit_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    redirect_valid = 1'b0; hit_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("miss_addr", l1i_address, 32'h40);
      chk("miss_busy", 32'(fetch_busy), 32'd1);
      @(posedge clock); #1;
    end
    hit_en = 1'b1;
    exp_q.push_back(32'h40);
    @(negedge clock);
    chk("miss_ret_busy", 32'(fetch_busy), 32'd0);
    step(1);
    hit_en = 1'b0;
    step(2);

    // redirect during a miss
    hit_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    redirect_valid = 1'b0; hit_en = 1'b0;
    step(2);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step(1);
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("drain_addr", l1i_address, 32'h40);
      chk("drain_busy", 32'(fetch_busy), 32'd1);
      @(posedge clock); #1;
    end
    hit_en = 1'b1;
    @(negedge clock);
    chk("drain_ret_busy", 32'(fetch_busy), 32'd1);
    chk("drain_ret_addr", l1i_address, 32'h40);
    step(1);
    exp_q.push_back(32'h100);
    @(negedge clock);
    chk("redir_addr", l1i_address, 32'h100);
    chk("redir_dropped", 32'(instr_valid), 32'd0);
    step(1);
    hit_en = 1'b0;
    step(2);

    // redirect in the same cycle as a pop, with a younger word buffered
    instr_ready = 1'b0; hit_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    exp_q.push_back(32'h8);
    step(1);
    @(negedge clock);
    chk("pop_redir_head", instr_pc, 32'h8);
    chk("pop_redir_addr", l1i_address, 32'h10);
    @(posedge clock); #1;
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h200);
    @(negedge clock);
    chk("pop_redir_flush", 32'(instr_valid), 32'd0);
    chk("pop_redir_addr2", l1i_address, 32'h200);
    step(1);
    hit_en = 1'b0;
    step(2);

    // PC wrap, then reset in the middle of a miss
    hit_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    step(1);
    hit_en = 1'b0;
    @(negedge clock);
    chk("wrap_addr", l1i_address, 32'h0);
    step(2);
    hit_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step(1);
    redirect_valid = 1'b0; hit_en = 1'b0;
    step(3);
    @(negedge clock);
    chk("mid_miss_addr", l1i_address, 32'h80);
    @(posedge clock); #1;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_miss_addr", l1i_address, 32'h0);
    chk("rst_miss_valid", 32'(instr_valid), 32'd0);

    step(2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
